// File: rtl/gprf_wb_ctrl.sv
// gprf_wb_ctrl -- write-back initiator for the general purpose register file.
//
// Two write sources share one register file write port: the ALU and the
// memory-load path. Each source offers a write over a valid/ready handshake.
// Accepted writes go into a small in-order FIFO, and the FIFO drains one write
// per cycle onto the register file port. Per-register occupancy counters
// produce the pending mask that decode uses for hazard stalls.
//
// Ports
//   clk, reset            : clock (rising edge) and asynchronous active-low reset
//   alu_valid/ready/addr/data : ALU write request channel
//   mem_valid/ready/addr/data : load write request channel
//   wb_hold               : freeze; no pop while high
//   wr_en/wr_addr/wr_data : register file write port (head of FIFO)
//   pending               : bit r set while a queued write targets register r
//   count, busy           : FIFO occupancy and (count != 0)

// Pending counter for one destination register. The count is how many
// queued writes target this register.
module gprf_pend_cnt #(
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic pend
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 1'b1;
        else if (dec && !inc)
            cnt <= cnt - 1'b1;
    end

    assign pend = (cnt != '0);
endmodule

module gprf_wb_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_W-1:0]         alu_addr,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      wb_hold,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [(1<<ADDR_W)-1:0]    pending,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

    wb_req_t          fifo_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    grant_e           last_grant;

    logic    full, alu_fire, mem_fire, push, pop;
    wb_req_t push_req, head;

    // Readiness is a function of registered state and the *other* source's
    // valid only. A pop in the same cycle does not free a slot for a push.
    assign full      = (count == CNT_W'(DEPTH));
    assign alu_ready = !full && (!mem_valid || last_grant == GRANT_MEM);
    assign mem_ready = !full && (!alu_valid || last_grant == GRANT_ALU);

    // The grant terms are mutually exclusive under contention, so at most
    // one of these fires in a cycle.
    assign alu_fire = alu_valid && alu_ready;
    assign mem_fire = mem_valid && mem_ready;
    assign push     = alu_fire || mem_fire;

    always_comb begin
        push_req = '{addr: alu_addr, data: alu_data};
        if (mem_fire)
            push_req = '{addr: mem_addr, data: mem_data};
    end

    assign busy    = (count != '0);
    assign pop     = busy && !wb_hold;
    assign head    = fifo_q[rd_ptr];
    assign wr_en   = pop;
    assign wr_addr = busy ? head.addr : '0;
    assign wr_data = busy ? head.data : '0;

    // Storage needs no reset; the outputs are masked by busy.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= push_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_grant <= GRANT_ALU;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (alu_fire)
                last_grant <= GRANT_ALU;
            else if (mem_fire)
                last_grant <= GRANT_MEM;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_pend
        logic inc, dec;
        assign inc = push && (push_req.addr == ADDR_W'(r));
        assign dec = pop  && (head.addr == ADDR_W'(r));

        gprf_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc),
            .dec   (dec),
            .pend  (pending[r])
        );
    end
endmodule

// File: tb/tb_gprf_wb_ctrl.sv
// Bench for gprf_wb_ctrl: directed test-plan steps followed by randomized
// traffic. All expectations are derived from a queue-based model of the
// write-back FIFO plus a round-robin grant flag.
module tb_gprf_wb_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid, mem_valid, wb_hold;
    logic       alu_ready, mem_ready;
    logic [2:0] alu_addr, mem_addr;
    logic [7:0] alu_data, mem_data;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] pending;
    logic [2:0] count;
    logic       busy;

    always #5 clk = ~clk;

    gprf_wb_ctrl #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_hold(wb_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending(pending), .count(count), .busy(busy)
    );

    // Register file fed by the DUT's write port.
    logic [7:0] rf_dut [8];
    always @(posedge clk) if (wr_en) rf_dut[wr_addr] <= wr_data;

    // Reference model
    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } ent_t;
    ent_t       q[$];
    bit         lg_mem;          // 1 when the last push came from MEM
    logic [7:0] rf_m [8];
    bit         a_fire, m_fire;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance model.
    task automatic step(input bit av, input bit [2:0] aa, input bit [7:0] ad,
                        input bit mv, input bit [2:0] ma, input bit [7:0] md,
                        input bit hold);
        bit         full, e_ar, e_mr, e_wen;
        logic [7:0] e_pend;
        logic [2:0] e_addr;
        logic [7:0] e_data;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        wb_hold   = hold;
        @(negedge clk);
        full   = (q.size() == 4);
        e_ar   = !full && (!mv || lg_mem);
        e_mr   = !full && (!av || !lg_mem);
        e_wen  = (q.size() != 0) && !hold;
        e_addr = (q.size() != 0) ? q[0].a : 3'd0;
        e_data = (q.size() != 0) ? q[0].d : 8'd0;
        e_pend = 8'h00;
        foreach (q[i]) e_pend[q[i].a] = 1'b1;
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("mem_ready", 32'(mem_ready), 32'(e_mr));
        chk("wr_en",     32'(wr_en),     32'(e_wen));
        chk("wr_addr",   32'(wr_addr),   32'(e_addr));
        chk("wr_data",   32'(wr_data),   32'(e_data));
        chk("pending",   32'(pending),   32'(e_pend));
        chk("count",     32'(count),     q.size());
        chk("busy",      32'(busy),      32'(q.size() != 0));
        a_fire = av && e_ar;
        m_fire = mv && e_mr;
        @(posedge clk);
        if (e_wen) begin
            rf_m[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (a_fire) begin
            q.push_back('{a: aa, d: ad});
            lg_mem = 1'b0;
        end else if (m_fire) begin
            q.push_back('{a: ma, d: md});
            lg_mem = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit hold);
        step(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 8'd0, hold);
    endtask

    // Drop reset now (asynchronously), check, and release on a later negedge.
    task automatic do_reset();
        reset = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0; wb_hold = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        #1;
        q.delete();
        lg_mem = 1'b0;
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         av, mv, hold;
        bit [2:0]   aa, ma;
        bit [7:0]   ad, md;
        reset = 1'b1;
        #2;

        // 1. Reset, then idle with no requests
        do_reset();
        idle(1'b0);
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_mem_ready", 32'(mem_ready), 32'd1);

        // 2. Single ALU write
        step(1'b1, 3'd3, 8'hC4, 1'b0, 3'd0, 8'd0, 1'b0);
        chk("t2_count1",   32'(count),   32'd1);
        chk("t2_pending",  32'(pending), 32'h08);
        chk("t2_wr_addr",  32'(wr_addr), 32'd3);
        chk("t2_wr_data",  32'(wr_data), 32'hC4);
        idle(1'b0);
        chk("t2_count0",   32'(count),   32'd0);
        chk("t2_pend0",    32'(pending), 32'h00);
        chk("t2_rf3",      32'(rf_dut[3]), 32'hC4);

        // 3. Contention: expect MEM, ALU, MEM, ALU grants
        repeat (4) step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
        repeat (2) idle(1'b0);
        chk("t3_rf1", 32'(rf_dut[1]), 32'h11);
        chk("t3_rf2", 32'(rf_dut[2]), 32'h22);

        // 4. Fill under hold, then drain
        step(1'b1, 3'd0, 8'hF1, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd4, 8'h55, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd5, 8'hAA, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd6, 8'h3C, 1'b0, 3'd0, 8'd0, 1'b1);
        chk("t4_count4",  32'(count),   32'd4);
        chk("t4_pending", 32'(pending), 32'h71);
        step(1'b1, 3'd2, 8'h77, 1'b1, 3'd2, 8'h77, 1'b1);   // both refused when full
        repeat (4) idle(1'b0);
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_rf0", 32'(rf_dut[0]), 32'hF1);
        chk("t4_rf4", 32'(rf_dut[4]), 32'h55);
        chk("t4_rf5", 32'(rf_dut[5]), 32'hAA);
        chk("t4_rf6", 32'(rf_dut[6]), 32'h3C);

        // 5. Same register twice
        step(1'b1, 3'd7, 8'hE7, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd7, 8'h9A, 1'b0, 3'd0, 8'd0, 1'b1);
        idle(1'b0);
        chk("t5_pend7_a", 32'(pending[7]), 32'd1);
        idle(1'b0);
        chk("t5_pend7_b", 32'(pending[7]), 32'd0);
        chk("t5_rf7",     32'(rf_dut[7]), 32'h9A);

        // 6. Reset mid-operation discards queued writes
        step(1'b1, 3'd1, 8'hD1, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd2, 8'hD2, 1'b0, 3'd0, 8'd0, 1'b1);
        step(1'b1, 3'd3, 8'hD3, 1'b0, 3'd0, 8'd0, 1'b1);
        chk("t6_count3", 32'(count), 32'd3);
        do_reset();
        repeat (3) idle(1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("t6_rf%0d", r), 32'(rf_dut[r]), 32'(rf_m[r]));

        // Randomized traffic; sources obey the hold-until-ready rule.
        av = 1'b0; mv = 1'b0; aa = '0; ma = '0; ad = '0; md = '0;
        for (int c = 0; c < 400; c++) begin
            if (!av || a_fire) begin
                av = ($urandom_range(0, 2) != 0);
                aa = 3'($urandom);
                ad = 8'($urandom);
            end
            if (!mv || m_fire) begin
                mv = ($urandom_range(0, 2) != 0);
                ma = 3'($urandom);
                md = 8'($urandom);
            end
            hold = ($urandom_range(0, 9) < 3);
            a_fire = 1'b0; m_fire = 1'b0;
            step(av, aa, ad, mv, ma, md, hold);
        end
        repeat (6) idle(1'b0);
        for (int r = 0; r < 8; r++) chk($sformatf("rand_rf%0d", r), 32'(rf_dut[r]), 32'(rf_m[r]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
